// File: rtl/multicycle_controller_if.sv
// Control/datapath bundle for the multi-cycle RV32I sequencer.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, adr_src, mem_read, mem_write,
    output ir_write, reg_write, result_src,
    output alu_src_a, alu_src_b, alu_op, imm_src,
    output retire, illegal, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, adr_src, mem_read, mem_write,
    input  ir_write, reg_write, result_src,
    input  alu_src_a, alu_src_b, alu_op, imm_src,
    input  retire, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing FSM with memory ready handshake
// and a sticky trap on illegal opcodes.
module multicycle_controller (
  input  logic clk,
  input  logic rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  state_e state_q, state_d;
  logic       pc_update, branch;
  logic       adr_src, mem_read, mem_write;
  logic       ir_write, reg_write, retire, illegal;
  logic [1:0] result_src, src_a, src_b, alu_op;
  logic [1:0] imm_src;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    imm_src = 2'b00;
    unique case (1'b1)
      bus.op == OP_SW:  imm_src = 2'b01;
      bus.op == OP_BEQ: imm_src = 2'b10;
      bus.op == OP_JAL: imm_src = 2'b11;
      default:          imm_src = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_op     = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jal target lands in ALUOut here.
        src_a = 2'b01;
        src_b = 2'b01;
        unique case (1'b1)
          bus.op == OP_LW,
          bus.op == OP_SW:   state_d = S_MEMADR;
          bus.op == OP_R:    state_d = S_EXECR;
          bus.op == OP_I:    state_d = S_EXECI;
          bus.op == OP_BEQ:  state_d = S_BEQ;
          bus.op == OP_JAL:  state_d = S_JAL;
          bus.op == OP_JALR: state_d = S_JALR;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = bus.mem_ready;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        src_a   = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JALR: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_LINK;
      end
      S_LINK: begin
        // rs1 already sits in register A, so rd==rs1 is harmless.
        src_a   = 2'b01;
        src_b   = 2'b10;
        state_d = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  assign bus.pc_write   = pc_update | (branch & bus.zero);
  assign bus.adr_src    = adr_src;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = src_a;
  assign bus.alu_src_b  = src_b;
  assign bus.alu_op     = alu_op;
  assign bus.imm_src    = imm_src;
  assign bus.retire     = retire;
  assign bus.illegal    = illegal;
  assign bus.state      = state_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle RV32I core. It steps one shared ALU, one unified instruction/data memory port and the register file through fetch, decode, execute, memory and writeback, one instruction at a time. It replaces single-cycle main decoding for the multi-cycle datapath and adds a ready handshake on memory, so wait states stall the sequence. Illegal opcodes send it to a sticky trap state.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  7  opcode from instruction register (valid from DECODE onward)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC load enable = pc_update | (branch & zero)
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  read request, held until mem_ready
- mem_write  out  1  write request, held until mem_ready
- ir_write  out  1  load IR and OldPC
- reg_write  out  1  register-file write enable
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 register A
- alu_src_b  out  2  00 rs2 register B, 01 immediate, 10 constant 4
- alu_op  out  2  00 add, 01 subtract (branch), 10 use funct fields
- imm_src  out  2  immediate format, combinational from op: 0000011/0010011/1100111 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, others -> 00
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky; high in TRAP
- state  out  4  current state encoding, for debug

## Operation
- Outputs are a Moore decode of the state. Exceptions: ir_write, pc_write in FETCH, and retire in MEMWRITE are also qualified by mem_ready or zero. Unlisted outputs are 0.
- FETCH (0): adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_update equal mem_ready.
  - If mem_ready, go to DECODE; otherwise stay.
- DECODE (1): alu_src_a=01, alu_src_b=01, alu_op=00. This computes the branch/jal target into ALUOut. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 1100111 -> JALR
  - any other op -> TRAP
- MEMADR (2): alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD (3): adr_src=1, mem_read=1. Stay until mem_ready, then go to MEMWB.
- MEMWB (4): result_src=01, reg_write=1, retire=1. Next is FETCH.
- MEMWRITE (5): adr_src=1, mem_write=1. retire=mem_ready. Stay until mem_ready, then go to FETCH.
- EXECR (6): alu_src_a=10, alu_src_b=00, alu_op=10. Next is ALUWB.
- ALUWB (7): result_src=00, reg_write=1, retire=1. Next is FETCH.
- EXECI (8): alu_src_a=10, alu_src_b=01, alu_op=10. Next is ALUWB.
- JAL (9): alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. The PC takes the target from ALUOut while the ALU forms OldPC+4. Next is ALUWB.
- BEQ (10): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, retire=1. Next is FETCH.
- JALR (11): alu_src_a=10, alu_src_b=01, alu_op=00, result_src=10, pc_update=1. Next is LINK.
- LINK (12): alu_src_a=01, alu_src_b=10, alu_op=00. Next is ALUWB, which writes OldPC+4 to rd.
  - rd==rs1 is safe because rs1 was already latched in register A.
- TRAP (13): all outputs 0 except illegal=1. Leaves only on rst.
- Encodings 14 and 15 are unreachable. If entered, go to TRAP.
- mem_read and mem_write are never both high. A request, once raised, is held with a stable address until mem_ready.

## Timing
- Reset: on any rising edge with rst=1, state becomes FETCH. rst has priority over every transition, including mid-access.
- After reset, mem_read=1, adr_src=0, alu_src_b=10 and result_src=10. All other outputs are 0 while mem_ready=0.
- Cycle counts with mem_ready=1 immediately:

| Instruction | Cycles |
|---|---|
| beq | 3 |
| R-type, I-type ALU, sw, jal | 4 |
| lw, jalr | 5 |

- Each memory wait cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored in all other states.
- BEQ: pc_write = zero, same cycle, combinational.
- retire is exactly one cycle per instruction. It is never asserted in TRAP.

## Test plan
- Reset, then R-type (op=0110011) with mem_ready tied high:
  - state sequence 0,1,6,7,0
  - reg_write only in cycle 4; retire once; alu_op=10 in EXECR
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD:
  - 10 cycles to retire
  - ir_write only in the cycle where mem_ready is high
  - mem_read and adr_src stable while waiting
- beq, run twice, once with zero=1 and once with zero=0:
  - pc_write pulses in BEQ only when zero=1
  - 3 cycles to retire in both cases
- jal, then jalr:
  - sequences 0,1,9,7 and 0,1,11,12,7
  - pc_write in JAL and in JALR; reg_write in ALUWB; result_src=10 in JALR
- Illegal op 1111111:
  - state goes 0,1,13; illegal=1 and holds for 20 cycles
  - no retire, pc_write, reg_write or mem_write
  - rst returns state to FETCH
- sw, with rst asserted during the MEMWRITE wait:
  - next state is FETCH, mem_write drops, no retire
